// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : nes_pad_responder
//  Purpose  : Pad-side model of the NES/SNES serial controller protocol.
//             Emulates the CD4021 parallel-in/serial-out register: while the
//             host holds nes_latch high the button word is loaded
//             transparently, then each rising edge of nes_clk shifts the next
//             bit out LSB-first on nes_data. Data is active-low.
//  Ports    : clk          - system clock, sole clock domain
//             reset        - synchronous, active-high reset
//             buttons      - parallel button word, pressed = 1
//             nes_latch    - host latch line, asynchronous to clk
//             nes_clk      - host shift clock, asynchronous to clk
//             nes_data     - registered serial data, pressed = 0
//             bits_sent    - bits shifted in the current frame (0..NUM_BITS)
//             frame_done   - 1-cycle pulse on the NUM_BITS-th shift edge
//             latched_word - button word captured at latch fall (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module nes_pad_responder #(
   parameter int   NUM_BITS    = 8,
   parameter int   SYNC_STAGES = 2,
   parameter logic FILL_VALUE  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BITS-1:0] buttons,
   input  logic                nes_latch,
   input  logic                nes_clk,
   output logic                nes_data,
   output logic [4:0]          bits_sent,
   output logic                frame_done,
   output logic [NUM_BITS-1:0] latched_word
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [4:0] C_NUM_BITS = 5'(NUM_BITS);

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   latch_sync_q, latch_sync_d;
   logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
   logic                     latch_dly_q, latch_dly_d;
   logic                     clk_dly_q, clk_dly_d;
   logic [NUM_BITS-1:0]      shift_reg_q, shift_reg_d;
   logic                     nes_data_q, nes_data_d;
   logic [4:0]               bits_sent_q, bits_sent_d;
   logic                     frame_done_q, frame_done_d;
   logic [NUM_BITS-1:0]      latched_word_q, latched_word_d;

   logic latch_s, clk_s;
   logic latch_rise, latch_fall, clk_rise;
   logic load_now;

   assign latch_s    = latch_sync_q[SYNC_STAGES-1];
   assign clk_s      = clk_sync_q[SYNC_STAGES-1];
   assign latch_rise = latch_s & ~latch_dly_q;
   assign latch_fall = ~latch_s & latch_dly_q;
   assign clk_rise   = clk_s & ~clk_dly_q;

   always_comb begin
      latch_sync_d   = {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
      clk_sync_d     = {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
      latch_dly_d    = latch_s;
      clk_dly_d      = clk_s;
      state_d        = state_q;
      shift_reg_d    = shift_reg_q;
      nes_data_d     = nes_data_q;
      bits_sent_d    = bits_sent_q;
      frame_done_d   = 1'b0;
      latched_word_d = latched_word_q;
      load_now       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (latch_s) load_now = 1'b1;
         end
         ST_LOAD: begin
            // LOAD is only ever entered with latch_s high, so leaving it is
            // always a latch fall; the register already holds the last load.
            if (latch_s) begin
               load_now = 1'b1;
            end else if (latch_fall) begin
               state_d        = ST_SHIFT;
               latched_word_d = ~shift_reg_q;
               bits_sent_d    = '0;
            end
         end
         ST_SHIFT: begin
            if (latch_rise) begin
               // Host restarted mid-frame: abandon it without frame_done.
               load_now = 1'b1;
            end else if (clk_rise) begin
               shift_reg_d = {FILL_VALUE, shift_reg_q[NUM_BITS-1:1]};
               nes_data_d  = shift_reg_q[1];
               bits_sent_d = bits_sent_q + 5'd1;
               if (bits_sent_q + 5'd1 == C_NUM_BITS) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            nes_data_d = FILL_VALUE;
            if (latch_s) load_now = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Transparent parallel load: latch dominates any shift clock activity.
      if (load_now) begin
         state_d     = ST_LOAD;
         shift_reg_d = ~buttons;
         nes_data_d  = ~buttons[0];
         bits_sent_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         latch_sync_q   <= '0;
         clk_sync_q     <= '0;
         latch_dly_q    <= 1'b0;
         clk_dly_q      <= 1'b0;
         shift_reg_q    <= {NUM_BITS{FILL_VALUE}};
         nes_data_q     <= 1'b1;
         bits_sent_q    <= '0;
         frame_done_q   <= 1'b0;
         latched_word_q <= '0;
      end else begin
         state_q        <= state_d;
         latch_sync_q   <= latch_sync_d;
         clk_sync_q     <= clk_sync_d;
         latch_dly_q    <= latch_dly_d;
         clk_dly_q      <= clk_dly_d;
         shift_reg_q    <= shift_reg_d;
         nes_data_q     <= nes_data_d;
         bits_sent_q    <= bits_sent_d;
         frame_done_q   <= frame_done_d;
         latched_word_q <= latched_word_d;
      end
   end

   assign nes_data     = nes_data_q;
   assign bits_sent    = bits_sent_q;
   assign frame_done   = frame_done_q;
   assign latched_word = latched_word_q;

endmodule
`default_nettype wire
